// File: rtl/orcastra_target.sv
// Orcastra link target: decodes bit-serial frames into one MAC register access.
// Optional address range check is enabled with `define PC_ADDR_CHECK_EN.
module orcastra_target #(
    parameter int                ADDR_W   = 18,
    parameter int                DATA_W   = 8,
    parameter int                TIMEOUT  = 255,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 18'h003FF
) (
    input  logic              hclk,
    input  logic              reset,
    input  logic              PC_Clk,
    input  logic              PC_Data_In,
    input  logic              PC_Ready,
    input  logic              PC_Reset,
    output logic              PC_Data_Out,
    output logic              PC_Ack,
    output logic              PC_Error,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack
);

    localparam int SH_W = ADDR_W + DATA_W;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_BUS_WR,
        S_BUS_RD,
        S_DONE
    } state_t;

    // Bit order in the synchroniser: {PC_Reset, PC_Ready, PC_Data_In, PC_Clk}
    logic [3:0]        sync1_q;
    logic [3:0]        sync2_q;
    logic              clk_prev_q;
    logic              rdy_prev_q;

    state_t            state_q,  state_d;
    logic [5:0]        bitcnt_q, bitcnt_d;
    logic [SH_W-1:0]   sh_q,     sh_d;
    logic [DATA_W-1:0] out_sh_q, out_sh_d;
    logic [TO_W-1:0]   tcnt_q,   tcnt_d;
    logic              ack_q,    ack_d;
    logic              err_q,    err_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    logic clk_s, din_s, rdy_s, link_en;
    logic clk_rise, rdy_rise, rdy_fall, rx_shift;
    logic addr_ok, is_wr, is_rd, to_hit;

    assign clk_s    = sync2_q[0];
    assign din_s    = sync2_q[1];
    assign rdy_s    = sync2_q[2];
    assign link_en  = sync2_q[3];
    assign clk_rise = clk_s & ~clk_prev_q;
    assign rdy_rise = rdy_s & ~rdy_prev_q;
    assign rdy_fall = ~rdy_s & rdy_prev_q;
    assign rx_shift = clk_rise & ~rdy_s;

`ifdef PC_ADDR_CHECK_EN
    assign addr_ok = (sh_q[ADDR_W-1:0] <= MAX_ADDR);
`else
    logic max_addr_unused;
    assign max_addr_unused = |MAX_ADDR;
    assign addr_ok = 1'b1;
`endif

    assign is_wr  = (bitcnt_q == 6'(SH_W)) && addr_ok;
    assign is_rd  = (bitcnt_q == 6'(ADDR_W)) && addr_ok;
    assign to_hit = (tcnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        out_sh_d = out_sh_q;
        tcnt_d   = tcnt_q;
        ack_d    = ack_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        if (!link_en) begin
            state_d  = S_IDLE;
            bitcnt_d = '0;
            sh_d     = '0;
            out_sh_d = '0;
            tcnt_d   = '0;
            ack_d    = 1'b0;
            err_d    = 1'b0;
        end else begin
            if (rx_shift) begin
                sh_d     = {sh_q[SH_W-2:0], din_s};
                out_sh_d = {out_sh_q[DATA_W-2:0], 1'b0};
                if (bitcnt_q != 6'h3F) begin
                    bitcnt_d = bitcnt_q + 6'd1;
                end
            end
            if (rdy_fall) begin
                bitcnt_d = '0;
            end

            unique case (state_q)
                S_IDLE: begin
                    // First data clock of the next exchange retires the status
                    if (rx_shift) begin
                        ack_d = 1'b0;
                        err_d = 1'b0;
                    end
                    if (rdy_rise) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    addr_d  = sh_q[ADDR_W-1:0];
                    wdata_d = sh_q[SH_W-1:ADDR_W];
                    tcnt_d  = '0;
                    unique case (1'b1)
                        is_wr:   state_d = S_BUS_WR;
                        is_rd:   state_d = S_BUS_RD;
                        default: begin
                            ack_d   = 1'b1;
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
                S_BUS_WR: begin
                    if (reg_ack) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (to_hit) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                S_BUS_RD: begin
                    if (reg_ack) begin
                        out_sh_d = reg_rdata;
                        ack_d    = 1'b1;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end else if (to_hit) begin
                        out_sh_d = '0;
                        ack_d    = 1'b1;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    if (rdy_fall) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            clk_prev_q <= 1'b0;
            rdy_prev_q <= 1'b0;
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            sh_q       <= '0;
            out_sh_q   <= '0;
            tcnt_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            sync1_q    <= {PC_Reset, PC_Ready, PC_Data_In, PC_Clk};
            sync2_q    <= sync1_q;
            clk_prev_q <= clk_s;
            rdy_prev_q <= rdy_s;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            sh_q       <= sh_d;
            out_sh_q   <= out_sh_d;
            tcnt_q     <= tcnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign PC_Data_Out = out_sh_q[DATA_W-1];
    assign PC_Ack      = ack_q;
    assign PC_Error    = err_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_wr      = (state_q == S_BUS_WR);
    assign reg_rd      = (state_q == S_BUS_RD);

endmodule

// File: tb/tb_orcastra_target.sv
// Bench for orcastra_target: serial frame driver, register-bus responder
// and scoreboard of expected bus requests and read-out bits.
module tb_orcastra_target;

    logic        hclk = 1'b0;
    logic        reset;
    logic        PC_Clk, PC_Data_In, PC_Ready, PC_Reset;
    logic        PC_Data_Out, PC_Ack, PC_Error;
    logic [17:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr, reg_rd;
    logic [7:0]  reg_rdata;
    logic        reg_ack;

    orcastra_target dut (
        .hclk        (hclk),
        .reset       (reset),
        .PC_Clk      (PC_Clk),
        .PC_Data_In  (PC_Data_In),
        .PC_Ready    (PC_Ready),
        .PC_Reset    (PC_Reset),
        .PC_Data_Out (PC_Data_Out),
        .PC_Ack      (PC_Ack),
        .PC_Error    (PC_Error),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit          is_wr;
        logic [17:0] addr;
        logic [7:0]  data;
    } bus_t;

    bus_t exp_q[$];
    logic out_q[$];
    bus_t mon_e;

    int total = 0;
    int bad   = 0;
    int req_count = 0;
    bit bus_en = 1'b1;
    int bus_delay = 2;
    int req_cyc = 0;
    bit req_seen = 1'b0;

    // Bus monitor (pops expected requests) and single-cycle ack responder
    always @(negedge hclk) begin
        if ((reg_wr || reg_rd) && !req_seen) begin
            req_seen = 1'b1;
            req_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected: got wr=%0b rd=%0b addr=%0h, want no request",
                         reg_wr, reg_rd, reg_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (reg_wr !== mon_e.is_wr || reg_rd !== !mon_e.is_wr ||
                    reg_addr !== mon_e.addr ||
                    (mon_e.is_wr && reg_wdata !== mon_e.data)) begin
                    bad++;
                    $display("FAIL bus_req: got wr=%0b addr=%0h data=%0h, want wr=%0b addr=%0h data=%0h",
                             reg_wr, reg_addr, reg_wdata, mon_e.is_wr, mon_e.addr, mon_e.data);
                end
            end
        end else if (!reg_wr && !reg_rd) begin
            req_seen = 1'b0;
        end
        reg_ack = 1'b0;
        if ((reg_wr || reg_rd) && bus_en) begin
            if (req_cyc == bus_delay) begin
                reg_ack = 1'b1;
                req_cyc = 0;
            end else begin
                req_cyc++;
            end
        end else begin
            req_cyc = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge hclk);
    endtask

    task automatic pc_pulse(input logic b);
        PC_Data_In = b;
        tick(3);
        PC_Clk = 1'b1;
        tick(3);
        PC_Clk = 1'b0;
        tick(3);
    endtask

    task automatic send_frame(input int nbits, input logic [25:0] val);
        for (int i = nbits - 1; i >= 0; i--) pc_pulse(val[i]);
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (PC_Ack !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (PC_Ack !== 1'b1) begin
            bad++;
            $display("FAIL ack_wait: got PC_Ack=%b after %0d cycles, want 1", PC_Ack, n);
        end
    endtask

    task automatic link_reset();
        PC_Reset = 1'b0;
        PC_Ready = 1'b0;
        PC_Clk   = 1'b0;
        tick(4);
        PC_Reset = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        PC_Clk = 1'b0; PC_Data_In = 1'b0; PC_Ready = 1'b0; PC_Reset = 1'b0;
        reg_rdata = 8'h00;
        tick(4);
        total++;
        if ({PC_Ack, PC_Error, PC_Data_Out, reg_wr, reg_rd} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, want 00000",
                     {PC_Ack, PC_Error, PC_Data_Out, reg_wr, reg_rd});
        end
        total++;
        if (reg_addr !== 18'h0 || reg_wdata !== 8'h0) begin
            bad++;
            $display("FAIL reset_bus: got addr=%0h data=%0h, want 0 0", reg_addr, reg_wdata);
        end
        reset = 1'b0;
        PC_Reset = 1'b1;
        tick(4);
        total++;
        if ({PC_Ack, PC_Error, reg_wr, reg_rd} !== 4'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got %b, want 0000",
                     {PC_Ack, PC_Error, reg_wr, reg_rd});
        end
    endtask

    task automatic test_write();
        bus_t e;
        e.is_wr = 1'b1; e.addr = 18'h00123; e.data = 8'hA5;
        exp_q.push_back(e);
        bus_delay = 3;
        send_frame(26, {8'hA5, 18'h00123});
        PC_Ready = 1'b1;
        wait_ack(60);
        total++;
        if (PC_Error !== 1'b0) begin
            bad++;
            $display("FAIL write_err: got %b, want 0", PC_Error);
        end
        total++;
        if (reg_addr !== 18'h00123 || reg_wdata !== 8'hA5 || reg_wr !== 1'b0) begin
            bad++;
            $display("FAIL write_hold: got addr=%0h data=%0h wr=%b, want 123 a5 0",
                     reg_addr, reg_wdata, reg_wr);
        end
        PC_Ready = 1'b0;
        tick(6);
        total++;
        if (PC_Ack !== 1'b1) begin
            bad++;
            $display("FAIL ack_hold: got %b, want 1", PC_Ack);
        end
        pc_pulse(1'b0);
        total++;
        if (PC_Ack !== 1'b0 || PC_Error !== 1'b0) begin
            bad++;
            $display("FAIL ack_clear: got ack=%b err=%b, want 0 0", PC_Ack, PC_Error);
        end
        link_reset();
    endtask

    task automatic test_read();
        bus_t e;
        logic [7:0] rd;
        logic eb;
        rd = 8'h3C;
        e.is_wr = 1'b0; e.addr = 18'h00040; e.data = 8'h00;
        exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) out_q.push_back(rd[i]);
        bus_delay = 0;
        reg_rdata = rd;
        send_frame(18, 26'h0000040);
        PC_Ready = 1'b1;
        wait_ack(60);
        total++;
        if (PC_Error !== 1'b0) begin
            bad++;
            $display("FAIL read_err: got %b, want 0", PC_Error);
        end
        PC_Ready = 1'b0;
        tick(6);
        for (int i = 0; i < 8; i++) begin
            eb = out_q.pop_front();
            total++;
            if (PC_Data_Out !== eb) begin
                bad++;
                $display("FAIL read_bit%0d: got %b, want %b", i, PC_Data_Out, eb);
            end
            pc_pulse(1'b0);
            if (i == 0) begin
                total++;
                if (PC_Ack !== 1'b0) begin
                    bad++;
                    $display("FAIL read_ack_clear: got %b, want 0", PC_Ack);
                end
            end
        end
        link_reset();
    endtask

    task automatic test_bad_frame();
        int lens[2];
        int rc;
        lens[0] = 20;
        lens[1] = 25;
        for (int k = 0; k < 2; k++) begin
            rc = req_count;
            send_frame(lens[k], 26'h2AB5F3C);
            PC_Ready = 1'b1;
            wait_ack(60);
            total++;
            if (PC_Error !== 1'b1) begin
                bad++;
                $display("FAIL bad_frame_err len=%0d: got %b, want 1", lens[k], PC_Error);
            end
            tick(10);
            total++;
            if (req_count != rc) begin
                bad++;
                $display("FAIL bad_frame_bus len=%0d: got %0d requests, want 0",
                         lens[k], req_count - rc);
            end
            link_reset();
        end
    endtask

    task automatic test_timeout();
        bus_t e;
        int n;
        int cnt;
        e.is_wr = 1'b0; e.addr = 18'h00077; e.data = 8'h00;
        exp_q.push_back(e);
        bus_en = 1'b0;
        reg_rdata = 8'hFF;
        send_frame(18, 26'h0000077);
        PC_Ready = 1'b1;
        n = 0;
        while (reg_rd !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        total++;
        if (reg_rd !== 1'b1) begin
            bad++;
            $display("FAIL timeout_req: got reg_rd=%b, want 1", reg_rd);
        end
        cnt = 0;
        while (reg_rd === 1'b1 && cnt < 400) begin
            cnt++;
            tick(1);
        end
        total++;
        if (cnt != 255) begin
            bad++;
            $display("FAIL timeout_len: got %0d cycles, want 255", cnt);
        end
        tick(2);
        total++;
        if (PC_Ack !== 1'b1 || PC_Error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_status: got ack=%b err=%b, want 1 1", PC_Ack, PC_Error);
        end
        bus_en = 1'b1;
        PC_Ready = 1'b0;
        tick(6);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (PC_Data_Out !== 1'b0) begin
                bad++;
                $display("FAIL timeout_bit%0d: got %b, want 0", i, PC_Data_Out);
            end
            pc_pulse(1'b0);
        end
        link_reset();
    endtask

    task automatic test_ack_at_timeout();
        bus_t e;
        logic [7:0] rd;
        logic eb;
        rd = 8'h96;
        e.is_wr = 1'b0; e.addr = 18'h00155; e.data = 8'h00;
        exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) out_q.push_back(rd[i]);
        bus_delay = 254;
        reg_rdata = rd;
        send_frame(18, 26'h0000155);
        PC_Ready = 1'b1;
        wait_ack(400);
        total++;
        if (PC_Error !== 1'b0) begin
            bad++;
            $display("FAIL ack_vs_timeout_err: got %b, want 0", PC_Error);
        end
        PC_Ready = 1'b0;
        tick(6);
        for (int i = 0; i < 8; i++) begin
            eb = out_q.pop_front();
            total++;
            if (PC_Data_Out !== eb) begin
                bad++;
                $display("FAIL ack_vs_timeout_bit%0d: got %b, want %b", i, PC_Data_Out, eb);
            end
            pc_pulse(1'b0);
        end
        bus_delay = 2;
        link_reset();
    endtask

    task automatic test_link_drop();
        bus_t e;
        int n;
        e.is_wr = 1'b1; e.addr = 18'h00200; e.data = 8'h5A;
        exp_q.push_back(e);
        bus_en = 1'b0;
        send_frame(26, {8'h5A, 18'h00200});
        PC_Ready = 1'b1;
        n = 0;
        while (reg_wr !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        total++;
        if (reg_wr !== 1'b1) begin
            bad++;
            $display("FAIL drop_req: got reg_wr=%b, want 1", reg_wr);
        end
        tick(5);
        PC_Reset = 1'b0;
        tick(3);
        total++;
        if (reg_wr !== 1'b0 || PC_Ack !== 1'b0 || PC_Error !== 1'b0) begin
            bad++;
            $display("FAIL drop_idle: got wr=%b ack=%b err=%b, want 0 0 0",
                     reg_wr, PC_Ack, PC_Error);
        end
        PC_Ready = 1'b0;
        tick(2);
        PC_Reset = 1'b1;
        tick(4);
        bus_en = 1'b1;
        bus_delay = 1;
        e.is_wr = 1'b1; e.addr = 18'h00321; e.data = 8'hC3;
        exp_q.push_back(e);
        send_frame(26, {8'hC3, 18'h00321});
        PC_Ready = 1'b1;
        wait_ack(60);
        total++;
        if (PC_Error !== 1'b0 || reg_addr !== 18'h00321 || reg_wdata !== 8'hC3) begin
            bad++;
            $display("FAIL drop_recover: got err=%b addr=%0h data=%0h, want 0 321 c3",
                     PC_Error, reg_addr, reg_wdata);
        end
        link_reset();
    endtask

`ifdef PC_ADDR_CHECK_EN
    task automatic test_addr_check();
        bus_t e;
        int rc;
        rc = req_count;
        send_frame(26, {8'h11, 18'h00400});
        PC_Ready = 1'b1;
        wait_ack(60);
        tick(5);
        total++;
        if (PC_Error !== 1'b1 || req_count != rc) begin
            bad++;
            $display("FAIL range_reject: got err=%b reqs=%0d, want 1 0",
                     PC_Error, req_count - rc);
        end
        link_reset();
        e.is_wr = 1'b1; e.addr = 18'h003FF; e.data = 8'h22;
        exp_q.push_back(e);
        send_frame(26, {8'h22, 18'h003FF});
        PC_Ready = 1'b1;
        wait_ack(60);
        total++;
        if (PC_Error !== 1'b0) begin
            bad++;
            $display("FAIL range_edge: got err=%b, want 0", PC_Error);
        end
        link_reset();
    endtask
`endif

    initial begin
        reg_ack = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_bad_frame();
        test_timeout();
        test_ack_at_timeout();
        test_link_drop();
`ifdef PC_ADDR_CHECK_EN
        test_addr_check();
`endif
        tick(5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending requests, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
